idct4_bloque: RTL and testbench

Pipelined 4-point HEVC inverse DCT: the decode-side counterpart of the forward 4-point `bloque` transform. It accepts four signed 17-bit coefficients per load cycle and produces four signed 9-bit residual samples. It applies the standard HEVC integer butterfly, then rounding, right-shift and optional clipping. It sits after dequantisation and before reconstruction, and accepts one vector per cycle with a fixed latency.

---
 rtl/dct_pkg.sv | 43 ++++
 rtl/idct4_bloque_if.sv | 34 +++
 rtl/idct4_round_clip.sv | 32 +++
 rtl/idct4_bloque.sv | 120 ++++++++++++
 tb/tb_idct4_bloque.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and arithmetic helpers for the 4-point HEVC
// forward/inverse transform blocks.
//   - HEVC 4-point basis coefficients (64, 83, 36)
//   - default WIDTH_X / WIDTH_Y / SHIFT
//   - round_shift : (v + 2^(sh-1)) >>> sh on a 32-bit signed value
//   - clip_signed : saturate a 32-bit signed value to a w-bit signed range
// Helpers work on 32-bit signed values, so accumulators must be <= 32 bits.
package dct_pkg;

  localparam int unsigned COEF_64 = 64;
  localparam int unsigned COEF_83 = 83;
  localparam int unsigned COEF_36 = 36;

  localparam int unsigned DEF_WIDTH_X = 17;
  localparam int unsigned DEF_WIDTH_Y = 9;
  localparam int unsigned DEF_SHIFT   = 7;

  localparam int unsigned HELPER_W = 32;

  // Round-half-up then arithmetic (floor) right shift; i_sh must be >= 1.
  function automatic logic signed [31:0] round_shift(input logic signed [31:0] i_v,
                                                     input int unsigned i_sh);
    logic signed [31:0] bias;
    bias = 32'sd1 <<< (i_sh - 1);
    return (i_v + bias) >>> i_sh;
  endfunction

  // Saturate to [-2^(w-1), 2^(w-1)-1].
  function automatic logic signed [31:0] clip_signed(input logic signed [31:0] i_v,
                                                     input int unsigned i_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (i_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (i_w - 1));
    if (i_v > hi) begin
      return hi;
    end else if (i_v < lo) begin
      return lo;
    end
    return i_v;
  endfunction

endpackage

// File: rtl/idct4_bloque_if.sv
// idct4_bloque_if: coefficient-in / residual-out bus of the 4-point IDCT.
//   load, x0..x3     : producer -> transform (one vector per load cycle)
//   valid, y0..y3, sat: transform -> consumer (one-cycle valid per result)
// Modports: master = producer/consumer side, slave = transform block.
interface idct4_bloque_if
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH_X = DEF_WIDTH_X,
  parameter int unsigned WIDTH_Y = DEF_WIDTH_Y
);

  logic                      load;
  logic signed [WIDTH_X-1:0] x0;
  logic signed [WIDTH_X-1:0] x1;
  logic signed [WIDTH_X-1:0] x2;
  logic signed [WIDTH_X-1:0] x3;
  logic                      valid;
  logic signed [WIDTH_Y-1:0] y0;
  logic signed [WIDTH_Y-1:0] y1;
  logic signed [WIDTH_Y-1:0] y2;
  logic signed [WIDTH_Y-1:0] y3;
  logic                      sat;

  modport master (
    output load, x0, x1, x2, x3,
    input  valid, y0, y1, y2, y3, sat
  );

  modport slave (
    input  load, x0, x1, x2, x3,
    output valid, y0, y1, y2, y3, sat
  );

endinterface

// File: rtl/idct4_round_clip.sv
// idct4_round_clip: one output lane of the IDCT final stage (combinational).
//   i_s     : butterfly sum, ACC_W-bit signed
//   o_y_c   : rounded, shifted and narrowed residual (WIDTH_Y-bit signed)
//   o_sat_c : lane was clipped (always 0 without clipping)
// Build option IDCT4_CLIP_EN: defined -> saturate to WIDTH_Y range,
// undefined -> keep low WIDTH_Y bits (wrap), no clip logic.
module idct4_round_clip
  import dct_pkg::*;
#(
  parameter int unsigned ACC_W   = DEF_WIDTH_X + 9,
  parameter int unsigned WIDTH_Y = DEF_WIDTH_Y,
  parameter int unsigned SHIFT   = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0]   i_s,
  output logic signed [WIDTH_Y-1:0] o_y_c,
  output logic                      o_sat_c
);

`ifdef IDCT4_CLIP_EN
  logic signed [HELPER_W-1:0] w_r;

  assign w_r = round_shift(HELPER_W'(i_s), SHIFT);

  // Clipping changed the value exactly when the lane saturated.
  assign o_y_c   = WIDTH_Y'(clip_signed(w_r, WIDTH_Y));
  assign o_sat_c = (clip_signed(w_r, WIDTH_Y) != w_r);
`else
  assign o_y_c   = WIDTH_Y'(round_shift(HELPER_W'(i_s), SHIFT));
  assign o_sat_c = 1'b0;
`endif

endmodule

// File: rtl/idct4_bloque.sv
// idct4_bloque: pipelined 4-point HEVC inverse DCT, 3 register stages,
// one vector per cycle, never stalls.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : idct4_bloque_if.slave (load/x0..x3 in, valid/y0..y3/sat out)
// Build option IDCT4_CLIP_EN selects saturation instead of wrap-around
// in the output lanes (see idct4_round_clip).
module idct4_bloque
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH_X = DEF_WIDTH_X,
  parameter int unsigned WIDTH_Y = DEF_WIDTH_Y,
  parameter int unsigned SHIFT   = DEF_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  idct4_bloque_if.slave  bus
);

  localparam int unsigned ACC_W = WIDTH_X + 9;
  localparam int unsigned LANES = 4;

  localparam logic signed [ACC_W-1:0] K64 = ACC_W'(COEF_64);
  localparam logic signed [ACC_W-1:0] K83 = ACC_W'(COEF_83);
  localparam logic signed [ACC_W-1:0] K36 = ACC_W'(COEF_36);

  logic signed [ACC_W-1:0]   w_c0, w_c1, w_c2, w_c3;
  logic signed [ACC_W-1:0]   r_e0, r_e1, r_o0, r_o1;
  logic                      r_v1;
  logic signed [ACC_W-1:0]   r_s [LANES];
  logic                      r_v2;
  logic signed [WIDTH_Y-1:0] w_y [LANES];
  logic [LANES-1:0]          w_lane_sat;
  logic signed [WIDTH_Y-1:0] r_y [LANES];
  logic                      r_sat;
  logic                      r_valid;

  // Sign-extend coefficients to the accumulator width.
  assign w_c0 = ACC_W'(bus.x0);
  assign w_c1 = ACC_W'(bus.x1);
  assign w_c2 = ACC_W'(bus.x2);
  assign w_c3 = ACC_W'(bus.x3);

  // Stage 1: even/odd terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e0 <= '0;
      r_e1 <= '0;
      r_o0 <= '0;
      r_o1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= bus.load;
      if (bus.load) begin
        r_e0 <= (w_c0 + w_c2) * K64;
        r_e1 <= (w_c0 - w_c2) * K64;
        r_o0 <= w_c1 * K83 + w_c3 * K36;
        r_o1 <= w_c1 * K36 - w_c3 * K83;
      end
    end
  end

  // Stage 2: butterfly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_s[i] <= '0;
      end
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s[0] <= r_e0 + r_o0;
        r_s[1] <= r_e1 + r_o1;
        r_s[2] <= r_e1 - r_o1;
        r_s[3] <= r_e0 - r_o0;
      end
    end
  end

  // Stage 3 lanes: round, shift, narrow.
  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    idct4_round_clip #(
      .ACC_W   (ACC_W),
      .WIDTH_Y (WIDTH_Y),
      .SHIFT   (SHIFT)
    ) u_lane (
      .i_s     (r_s[g]),
      .o_y_c   (w_y[g]),
      .o_sat_c (w_lane_sat[g])
    );
  end

  // Stage 3 output register; y/sat hold between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_y[i] <= '0;
      end
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) begin
        for (int i = 0; i < int'(LANES); i++) begin
          r_y[i] <= w_y[i];
        end
        r_sat <= |w_lane_sat;
      end
    end
  end

  assign bus.valid = r_valid;
  assign bus.y0    = r_y[0];
  assign bus.y1    = r_y[1];
  assign bus.y2    = r_y[2];
  assign bus.y3    = r_y[3];
  assign bus.sat   = r_sat;

endmodule

// File: tb/tb_idct4_bloque.sv
// tb_idct4_bloque: scoreboard bench for idct4_bloque. Expected residuals come
// from an integer reference model (IDCT4_CLIP_EN selects clip or wrap), are
// queued with their due cycle when a vector is driven, and are compared when
// the output is sampled on the falling edge.
module tb_idct4_bloque;

  localparam int unsigned WX = 17;
  localparam int unsigned WY = 9;
  localparam int unsigned SH = 7;

  typedef struct {
    longint y0, y1, y2, y3;
    longint sat;
    longint due;
  } exp_t;

  logic   clk;
  logic   rst;
  longint cyc;
  int     errors;
  int     checks;
  exp_t   sb_q[$];
  exp_t   last;

  idct4_bloque_if #(.WIDTH_X(WX), .WIDTH_Y(WY)) bus ();

  idct4_bloque #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint lane_model(input longint s, output longint sat);
    longint r;
    logic signed [WY-1:0] w;
    r   = (s + (64'sd1 <<< (SH - 1))) >>> SH;
    sat = 0;
`ifdef IDCT4_CLIP_EN
    if (r > 255) begin
      r = 255; sat = 1;
    end else if (r < -256) begin
      r = -256; sat = 1;
    end
`else
    w = r[WY-1:0];
    r = longint'(w);
`endif
    return r;
  endfunction

  function automatic exp_t model(input longint c0, input longint c1,
                                 input longint c2, input longint c3);
    exp_t e;
    longint e0, e1, o0, o1, s0, s1, s2, s3;
    e0 = 64 * (c0 + c2);
    e1 = 64 * (c0 - c2);
    o0 = 83 * c1 + 36 * c3;
    o1 = 36 * c1 - 83 * c3;
    e.y0 = lane_model(e0 + o0, s0);
    e.y1 = lane_model(e1 + o1, s1);
    e.y2 = lane_model(e1 - o1, s2);
    e.y3 = lane_model(e0 - o0, s3);
    e.sat = ((s0 | s1 | s2 | s3) != 0) ? 1 : 0;
    e.due = 0;
    return e;
  endfunction

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int c0, input int c1, input int c2, input int c3);
    exp_t e;
    bus.load = 1'b1;
    bus.x0 = WX'(c0);
    bus.x1 = WX'(c1);
    bus.x2 = WX'(c2);
    bus.x3 = WX'(c3);
    e = model(c0, c1, c2, c3);
    e.due = cyc + 3;
    sb_q.push_back(e);
    step();
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.load = 1'b0;
    repeat (n) step();
  endtask

  // Output monitor: valid must appear exactly on the due cycle; outputs hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_v;
    exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
    check_val("valid", longint'(bus.valid), longint'(exp_v));
    if (bus.valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("y0", longint'(bus.y0), e.y0);
      check_val("y1", longint'(bus.y1), e.y1);
      check_val("y2", longint'(bus.y2), e.y2);
      check_val("y3", longint'(bus.y3), e.y3);
      check_val("sat", longint'(bus.sat), e.sat);
      last = e;
    end else if (!bus.valid) begin
      check_val("hold_y0", longint'(bus.y0), last.y0);
      check_val("hold_y1", longint'(bus.y1), last.y1);
      check_val("hold_y2", longint'(bus.y2), last.y2);
      check_val("hold_y3", longint'(bus.y3), last.y3);
      check_val("hold_sat", longint'(bus.sat), last.sat);
    end
  end

  initial begin
    int r0, r1, r2, r3;
    errors = 0;
    checks = 0;
    cyc = 0;
    last = '{default: 0};
    rst = 1'b0;
    // load during reset must be ignored
    bus.load = 1'b1;
    bus.x0 = WX'(64);
    bus.x1 = WX'(64);
    bus.x2 = '0;
    bus.x3 = '0;
    repeat (3) step();
    check_val("rst_valid", longint'(bus.valid), 0);
    check_val("rst_y0", longint'(bus.y0), 0);
    rst = 1'b1;
    idle(3);

    // DC and first odd coefficient
    drive_vec(64, 0, 0, 0);
    idle(4);
    drive_vec(0, 64, 0, 0);
    idle(4);

    // Full-scale positive / negative DC: clip or wrap
    drive_vec(65535, 0, 0, 0);
    idle(4);
    drive_vec(-65536, 0, 0, 0);
    idle(4);

    // Back-to-back vectors
    drive_vec(64, 0, 0, 0);
    drive_vec(0, 64, 0, 0);
    drive_vec(0, 0, 0, 0);
    drive_vec(64, 0, 0, 0);
    idle(4);

    // Isolated loads with a one-cycle gap
    drive_vec(0, 0, 100, 0);
    idle(1);
    drive_vec(0, 0, 0, -77);
    idle(4);

    // Random full-range vectors, back to back
    for (int i = 0; i < 8; i++) begin
      r0 = int'($urandom_range(0, 131071)) - 65536;
      r1 = int'($urandom_range(0, 131071)) - 65536;
      r2 = int'($urandom_range(0, 131071)) - 65536;
      r3 = int'($urandom_range(0, 131071)) - 65536;
      drive_vec(r0, r1, r2, r3);
    end
    idle(4);

    // Reset one cycle after a load: in-flight vector is discarded
    drive_vec(0, 64, 0, 0);
    rst = 1'b0;
    sb_q.delete();
    last = '{default: 0};
    #1;
    check_val("midrst_valid", longint'(bus.valid), 0);
    check_val("midrst_y0", longint'(bus.y0), 0);
    check_val("midrst_y1", longint'(bus.y1), 0);
    check_val("midrst_y2", longint'(bus.y2), 0);
    check_val("midrst_y3", longint'(bus.y3), 0);
    check_val("midrst_sat", longint'(bus.sat), 0);
    idle(2);
    rst = 1'b1;
    idle(5);

    // Vector sampled on the first edge after reset release
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    drive_vec(64, 0, 0, 0);
    idle(5);

    check_val("drain", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
